// File: rtl/frac_logic_kcfg.sv
// frac_logic_kcfg -- fracturable K-input LUT with an arithmetic mode, programmed
// through a counted configuration shift segment with a shadow/active split.
//
// Bits are shifted into a shadow chain. They are copied to the active config
// only when a session ends with exactly the right bit count, so a short,
// partial or overlong load never disturbs live logic.
//
// Config layout (active): [2**K-1:0] LUT table, [2**K] out0_sel, [2**K+1] arith_mode.
// The first bit shifted ends up in the MSB, so arith_mode is shifted first.
//
// Optional feature: define FRAC_LOGIC_CFG_PARITY_EN to add one trailing
// even-parity bit to the chain. That bit is shifted last and sits at shadow
// bit 0. A load commits only when the bit count is right and parity is good.
//
// Ports:
//   prog_clk         config/register clock, rising edge
//   pReset           asynchronous reset, active-high
//   config_enable    1 = shift chain active
//   ccff_head        serial config in
//   ccff_tail        serial config out (MSB of the shadow chain)
//   frac_logic_in    K LUT inputs, bit0 = LSB of the table index
//   frac_logic_cin   carry in
//   frac_logic_out   [0] = K-LUT or lower LUT, [1] = upper LUT or sum
//   frac_logic_cout  carry out
//   cfg_valid        active config holds a committed load
//   cfg_error        last load session was rejected
module frac_logic_kcfg #(
  parameter int K = 4
) (
  input  logic         prog_clk,
  input  logic         pReset,
  input  logic         config_enable,
  input  logic         ccff_head,
  output logic         ccff_tail,
  input  logic [K-1:0] frac_logic_in,
  input  logic         frac_logic_cin,
  output logic [1:0]   frac_logic_out,
  output logic         frac_logic_cout,
  output logic         cfg_valid,
  output logic         cfg_error
);
  localparam int TBL   = 2**K;
  localparam int CFG_W = TBL + 2;
`ifdef FRAC_LOGIC_CFG_PARITY_EN
  localparam int CH_W  = CFG_W + 1;
`else
  localparam int CH_W  = CFG_W;
`endif
  // The counter saturates one past the expected length, so any overlong
  // session is still seen as a miscount.
  localparam int CNT_MAX = CH_W + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CHECK} state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   shadow;
  logic [CFG_W-1:0]  active;
  logic [CNT_W-1:0]  cnt;
  logic              do_shift, cnt_first, do_check, load_ok, parity_ok;

  // ---------------- FSM: next state / controls ----------------
  always_comb begin
    state_nxt = state;
    do_shift  = 1'b0;
    cnt_first = 1'b0;
    do_check  = 1'b0;
    case (state)
      S_IDLE:
        if (config_enable) begin
          state_nxt = S_SHIFT;
          do_shift  = 1'b1;
          cnt_first = 1'b1;
        end
      S_SHIFT:
        if (config_enable) do_shift  = 1'b1;
        else               state_nxt = S_CHECK;
      // The check always completes. An enable seen here is picked up by
      // IDLE on the following edge.
      S_CHECK: begin
        do_check  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef FRAC_LOGIC_CFG_PARITY_EN
  assign parity_ok = ~^shadow;
`else
  assign parity_ok = 1'b1;
`endif
  assign load_ok = (cnt == CNT_W'(CH_W)) && parity_ok;

  // ---------------- state, chain, counter, active config ----------------
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state     <= S_IDLE;
      shadow    <= '0;
      active    <= '0;
      cnt       <= '0;
      cfg_valid <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      state <= state_nxt;
      if (do_shift) shadow <= {shadow[CH_W-2:0], ccff_head};
      if (cnt_first)
        cnt <= CNT_W'(1);
      else if (do_shift && cnt != CNT_W'(CNT_MAX))
        cnt <= cnt + CNT_W'(1);
      if (do_check) begin
        if (load_ok) begin
          active    <= shadow[CH_W-1 -: CFG_W];
          cfg_valid <= 1'b1;
          cfg_error <= 1'b0;
        end else begin
          cfg_error <= 1'b1;
        end
      end
    end
  end

  assign ccff_tail = shadow[CH_W-1];

  // ---------------- LUT / arithmetic datapath ----------------
  logic [TBL-1:0] tbl;
  logic           out0_sel, arith;
  logic [K-2:0]   idx;
  logic           lo, hi, lutk;

  assign tbl      = active[TBL-1:0];
  assign out0_sel = active[TBL];
  assign arith    = active[TBL+1];
  assign idx      = frac_logic_in[K-2:0];
  // The two (K-1)-LUTs are the lower and upper halves of the table. The top
  // input picks between them to form the full K-LUT.
  assign lo       = tbl[{1'b0, idx}];
  assign hi       = tbl[{1'b1, idx}];
  assign lutk     = frac_logic_in[K-1] ? hi : lo;

  always_comb begin
    frac_logic_out  = 2'b00;
    frac_logic_cout = 1'b0;
    if (cfg_valid) begin
      frac_logic_out[0] = out0_sel ? lutk : lo;
      if (arith) begin
        // Propagate = lower half, generate = upper half.
        frac_logic_out[1] = lo ^ frac_logic_cin;
        frac_logic_cout   = hi | (lo & frac_logic_cin);
      end else begin
        frac_logic_out[1] = hi;
      end
    end
  end

endmodule

// File: tb/tb_frac_logic_kcfg.sv
module tb_frac_logic_kcfg;
  localparam int K     = 4;
  localparam int HALF  = 2**(K-1);
  localparam int CFG_W = 2**K + 2;
`ifdef FRAC_LOGIC_CFG_PARITY_EN
  localparam int CH_W  = CFG_W + 1;
`else
  localparam int CH_W  = CFG_W;
`endif

  logic         prog_clk = 1'b0;
  logic         pReset, config_enable, ccff_head, ccff_tail;
  logic [K-1:0] frac_logic_in;
  logic         frac_logic_cin;
  logic [1:0]   frac_logic_out;
  logic         frac_logic_cout, cfg_valid, cfg_error;

  frac_logic_kcfg #(.K(K)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .config_enable(config_enable),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail),
    .frac_logic_in(frac_logic_in), .frac_logic_cin(frac_logic_cin),
    .frac_logic_out(frac_logic_out), .frac_logic_cout(frac_logic_cout),
    .cfg_valid(cfg_valid), .cfg_error(cfg_error)
  );

  always #5 prog_clk = ~prog_clk;

  typedef bit bq_t[$];
  typedef struct {
    string      name;
    logic [1:0] out;
    logic       cout, valid, err, tail;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_pass = 0;

  // Reference state: every bit shifted since reset, committed config, flags.
  bit               hist[$];
  logic [CFG_W-1:0] m_act;
  bit               m_valid, m_err;

  function automatic exp_t model(string name);
    exp_t e;
    int idx, lo, hi, lutk, ci;
    e.name  = name;
    e.valid = m_valid;
    e.err   = m_err;
    // Shadow MSB is the bit shifted CH_W shifts ago (zero if none yet).
    e.tail  = (hist.size() >= CH_W) ? hist[hist.size()-CH_W] : 1'b0;
    e.out   = 2'b00;
    e.cout  = 1'b0;
    if (m_valid) begin
      idx  = int'(frac_logic_in) % HALF;
      ci   = int'(frac_logic_cin);
      lo   = int'(m_act[idx]);
      hi   = int'(m_act[idx + HALF]);
      lutk = (int'(frac_logic_in) >= HALF) ? hi : lo;
      e.out[0] = (m_act[2**K] ? lutk : lo) != 0;
      if (m_act[2**K+1]) begin
        // Two-bit add: hi counts as weight 2 (generate), lo as weight 1.
        e.out[1] = ((lo + ci) % 2) != 0;
        e.cout   = (2*hi + lo + ci) >= 2;
      end else begin
        e.out[1] = hi != 0;
      end
    end
    return e;
  endfunction

  function automatic bq_t mk(logic [CFG_W-1:0] c, bit flip);
    bq_t q;
    for (int i = CFG_W-1; i >= 0; i--) q.push_back(c[i]);
`ifdef FRAC_LOGIC_CFG_PARITY_EN
    q.push_back(^c);
`endif
    if (flip) q[3] = ~q[3];
    return q;
  endfunction

  function automatic void session_end(bq_t b);
    int ones = 0;
    bit par_ok = 1'b1;
    foreach (b[i]) ones += int'(b[i]);
`ifdef FRAC_LOGIC_CFG_PARITY_EN
    par_ok = (ones % 2) == 0;
`endif
    if (b.size() == CH_W && par_ok) begin
      for (int i = 0; i < CFG_W; i++) m_act[CFG_W-1-i] = b[i];
      m_valid = 1'b1;
      m_err   = 1'b0;
    end else begin
      m_err = 1'b1;
    end
  endfunction

  task automatic edge_();
    @(posedge prog_clk); #1;
  endtask

  task automatic rnd_in();
    frac_logic_in  = K'($urandom);
    frac_logic_cin = 1'($urandom);
  endtask

  task automatic push(string name);
    sb.push_back(model(name));
  endtask

  task automatic idle(int n, string name);
    repeat (n) begin edge_(); rnd_in(); push(name); end
  endtask

  task automatic drive(logic [K-1:0] in, logic cin, string name);
    edge_(); frac_logic_in = in; frac_logic_cin = cin; push(name);
  endtask

  task automatic shift_bits(bq_t b, bit finish, string name);
    foreach (b[i]) begin
      config_enable = 1'b1;
      ccff_head     = b[i];
      edge_();
      hist.push_back(b[i]);
      rnd_in();
      push(name);
    end
    if (finish) begin
      config_enable = 1'b0;
      ccff_head     = 1'($urandom);
      edge_(); rnd_in(); push(name);   // SHIFT -> CHECK, no shift
      edge_(); session_end(b); rnd_in(); push(name);
    end
  endtask

  task automatic do_reset(int n);
    @(negedge prog_clk); #1;
    pReset = 1'b1;
    config_enable = 1'b0;
    hist.delete();
    m_act = '0; m_valid = 1'b0; m_err = 1'b0;
    idle(n, "reset");
    pReset = 1'b0;
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge prog_clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_chk++;
      if ({frac_logic_out, frac_logic_cout, cfg_valid, cfg_error, ccff_tail} ===
          {e.out, e.cout, e.valid, e.err, e.tail})
        n_pass++;
      else
        $display("FAIL %s @%0t: got out=%b cout=%b valid=%b err=%b tail=%b, want out=%b cout=%b valid=%b err=%b tail=%b",
                 e.name, $time, frac_logic_out, frac_logic_cout, cfg_valid, cfg_error, ccff_tail,
                 e.out, e.cout, e.valid, e.err, e.tail);
    end
  end

  initial begin
    bq_t q, q2;
    logic [CFG_W-1:0] c;
    pReset = 1'b0; config_enable = 1'b0; ccff_head = 1'b0;
    frac_logic_in = '0; frac_logic_cin = 1'b0;

    do_reset(3);
    idle(4, "no_load");

    // Majority table in both halves, arithmetic mode.
    shift_bits(mk({1'b1, 1'b0, 16'hE8E8}, 1'b0), 1'b1, "load_maj");
    drive(4'b1011, 1'b1, "maj_carry");
    drive(4'b0011, 1'b1, "maj_carry_lo");
    drive(4'b0000, 1'b1, "maj_sum");
    idle(6, "maj_rand");

    // K-LUT AND in logic mode with out0 selecting the full LUT.
    shift_bits(mk({1'b0, 1'b1, 16'h8000}, 1'b0), 1'b1, "load_and");
    drive(4'hF, 1'b0, "and_F");
    drive(4'h7, 1'b0, "and_7");
    idle(4, "and_rand");

    // Short and long sessions must leave the live config alone.
    q = mk(CFG_W'({$urandom, $urandom}), 1'b0);
    void'(q.pop_back());
    shift_bits(q, 1'b1, "short");
    drive(4'hF, 1'b0, "short_hold");
    q = mk(CFG_W'({$urandom, $urandom}), 1'b0);
    q.push_back(1'b1);
    shift_bits(q, 1'b1, "long");
    drive(4'hF, 1'b0, "long_hold");

    // Pass-through of two chain lengths: tail replays the first load.
    q  = mk(CFG_W'({$urandom, $urandom}), 1'b0);
    q2 = mk(CFG_W'({$urandom, $urandom}), 1'b0);
    foreach (q2[i]) q.push_back(q2[i]);
    shift_bits(q, 1'b1, "pass");
    idle(3, "pass_idle");

    // Reset in the middle of a shift, then a clean load.
    q = mk(CFG_W'({$urandom, $urandom}), 1'b0);
    q = q[0:8];
    shift_bits(q, 1'b0, "mid_shift");
    do_reset(2);
    shift_bits(mk(CFG_W'({$urandom, $urandom}), 1'b0), 1'b1, "clean_load");
    idle(4, "clean_rand");

    // One corrupted bit: rejected with parity, a different commit without.
    shift_bits(mk(CFG_W'({$urandom, $urandom}), 1'b1), 1'b1, "flip");
    idle(3, "flip_rand");

    for (int r = 0; r < 8; r++) begin
      c = CFG_W'({$urandom, $urandom});
      q = mk(c, 1'b0);
      case ($urandom_range(0, 3))
        0: void'(q.pop_back());
        3: q.push_back(1'($urandom));
        default: ;
      endcase
      shift_bits(q, 1'b1, "rand_load");
      idle(int'($urandom_range(1, 4)), "rand_idle");
    end

    for (int t = 0; t < 50 && sb.size() > 0; t++) @(negedge prog_clk);
    #2;
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
